// File: rtl/inst_fifo_dual_if.sv
// Fetch/decode bus of the dual-issue instruction buffer.
// The slave modport is the FIFO's view; master is the fetch/decode side.
interface inst_fifo_dual_if #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int PACK_W = 36
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush_i;
    logic [INST_W-1:0] in_inst1_i,  in_inst2_i;
    logic [ADDR_W-1:0] in_addr1_i,  in_addr2_i;
    logic [PACK_W-1:0] in_pack0_i,  in_pack1_i;
    logic              in_valid1_i, in_valid2_i;
    logic              full_o;
    logic [INST_W-1:0] out_inst1_o, out_inst2_o;
    logic [ADDR_W-1:0] out_addr1_o, out_addr2_o;
    logic [PACK_W-1:0] out_pack0_o, out_pack1_o;
    logic              out_valid1_o, out_valid2_o;
    logic [1:0]        issue_num_i;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  flush_i, in_inst1_i, in_inst2_i, in_addr1_i, in_addr2_i,
               in_pack0_i, in_pack1_i, in_valid1_i, in_valid2_i, issue_num_i,
        output full_o, out_inst1_o, out_inst2_o, out_addr1_o, out_addr2_o,
               out_pack0_o, out_pack1_o, out_valid1_o, out_valid2_o, count_o
    );

    modport master (
        output flush_i, in_inst1_i, in_inst2_i, in_addr1_i, in_addr2_i,
               in_pack0_i, in_pack1_i, in_valid1_i, in_valid2_i, issue_num_i,
        input  full_o, out_inst1_o, out_inst2_o, out_addr1_o, out_addr2_o,
               out_pack0_o, out_pack1_o, out_valid1_o, out_valid2_o, count_o
    );
endinterface

// File: rtl/inst_fifo_dual.sv
// Instruction buffer between ICache and decode: 2-wide push, 2-wide
// first-word-fall-through read, 0/1/2 retire per cycle, flush.
module inst_fifo_dual #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int PACK_W = 36
) (
    input  logic               clk,
    input  logic               rst,
    inst_fifo_dual_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic [PACK_W-1:0] pack;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, tail_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       push_n, pop_n, iss;
    logic             full;
    entry_t           wr_ent [2];
    entry_t           rd_ent [2];
    logic [1:0]       rd_vld;

    // Fewer than two free slots stalls fetch, so even a single push waits.
    assign full    = count_q > CNT_W'(DEPTH - 2);
    assign tail_p1 = tail_q + PTR_W'(1);
    assign wr_ent[0] = '{inst: bus.in_inst1_i, addr: bus.in_addr1_i, pack: bus.in_pack0_i};
    assign wr_ent[1] = '{inst: bus.in_inst2_i, addr: bus.in_addr2_i, pack: bus.in_pack1_i};

    // Push/pop amounts and next pointer state; flush overrides everything.
    always_comb begin
        push_n  = 2'd0;
        if (!full && bus.in_valid1_i)
            push_n = bus.in_valid2_i ? 2'd2 : 2'd1;
        iss     = bus.issue_num_i[1] ? 2'd2 : bus.issue_num_i;
        pop_n   = (CNT_W'(iss) > count_q) ? count_q[1:0] : iss;
        head_d  = head_q + PTR_W'(pop_n);
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        if (bus.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are not reset, occupancy decides what is live.
    always_ff @(posedge clk) begin
        if (!bus.flush_i && push_n != 2'd0) begin
            mem_q[tail_q] <= wr_ent[0];
            if (push_n == 2'd2)
                mem_q[tail_p1] <= wr_ent[1];
        end
    end

    // Two read lanes at head and head+1; data forced to zero when not valid.
    for (genvar l = 0; l < 2; l++) begin : g_rd
        logic [PTR_W-1:0] ptr;
        assign ptr       = head_q + PTR_W'(l);
        assign rd_vld[l] = count_q > CNT_W'(l);
        assign rd_ent[l] = rd_vld[l] ? mem_q[ptr] : '0;
    end

    assign bus.full_o       = full;
    assign bus.count_o      = count_q;
    assign bus.out_valid1_o = rd_vld[0];
    assign bus.out_valid2_o = rd_vld[1];
    assign bus.out_inst1_o  = rd_ent[0].inst;
    assign bus.out_addr1_o  = rd_ent[0].addr;
    assign bus.out_pack0_o  = rd_ent[0].pack;
    assign bus.out_inst2_o  = rd_ent[1].inst;
    assign bus.out_addr2_o  = rd_ent[1].addr;
    assign bus.out_pack1_o  = rd_ent[1].pack;
endmodule

// File: tb/tb_inst_fifo_dual.sv
// Bench for inst_fifo_dual: directed vector table, corner sequences and
// random traffic, all checked against a queue-based model.
module tb_inst_fifo_dual;
    localparam int DEPTH = 16;

    logic clk, rst;
    int   errors = 0;
    int   checks = 0;

    inst_fifo_dual_if #(.DEPTH(DEPTH)) bus ();
    inst_fifo_dual #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [35:0] pack;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic        v1, v2, fl;
        logic [1:0]  iss;
        logic [31:0] a1, a2;
        int          ecnt;
        logic        efull, ev1, ev2;
        logic [31:0] ea1, ea2;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v1, input logic v2, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [1:0] iss, input logic fl);
        bus.in_valid1_i = v1;
        bus.in_valid2_i = v2;
        bus.in_addr1_i  = a1;
        bus.in_addr2_i  = a2;
        bus.in_inst1_i  = ~a1;
        bus.in_inst2_i  = ~a2;
        bus.in_pack0_i  = {a1[3:0] ^ 4'h5, a1};
        bus.in_pack1_i  = {a2[3:0] ^ 4'hA, a2};
        bus.issue_num_i = iss;
        bus.flush_i     = fl;
    endtask

    // Model: a plain queue; pop the oldest, then append the accepted new ones.
    task automatic model_edge();
        int n, ni, pop, pushn;
        ent_t e;
        if (!rst || bus.flush_i) begin
            q.delete();
            return;
        end
        n     = q.size();
        ni    = (bus.issue_num_i == 2'd3) ? 2 : int'(bus.issue_num_i);
        pop   = (ni < n) ? ni : n;
        pushn = (DEPTH - n >= 2 && bus.in_valid1_i) ? (bus.in_valid2_i ? 2 : 1) : 0;
        repeat (pop) void'(q.pop_front());
        if (pushn >= 1) begin
            e.inst = bus.in_inst1_i; e.addr = bus.in_addr1_i; e.pack = bus.in_pack0_i;
            q.push_back(e);
        end
        if (pushn == 2) begin
            e.inst = bus.in_inst2_i; e.addr = bus.in_addr2_i; e.pack = bus.in_pack1_i;
            q.push_back(e);
        end
    endtask

    task automatic check_model(input string tag);
        int   n;
        ent_t z, e0, e1;
        n  = q.size();
        z  = '{inst: 0, addr: 0, pack: 0};
        e0 = (n >= 1) ? q[0] : z;
        e1 = (n >= 2) ? q[1] : z;
        chk({tag, ".count"},  64'(bus.count_o),      64'(n));
        chk({tag, ".full"},   64'(bus.full_o),       64'(DEPTH - n < 2));
        chk({tag, ".valid1"}, 64'(bus.out_valid1_o), 64'(n >= 1));
        chk({tag, ".valid2"}, 64'(bus.out_valid2_o), 64'(n >= 2));
        chk({tag, ".addr1"},  64'(bus.out_addr1_o),  64'(e0.addr));
        chk({tag, ".inst1"},  64'(bus.out_inst1_o),  64'(e0.inst));
        chk({tag, ".pack0"},  64'(bus.out_pack0_o),  64'(e0.pack));
        chk({tag, ".addr2"},  64'(bus.out_addr2_o),  64'(e1.addr));
        chk({tag, ".inst2"},  64'(bus.out_inst2_o),  64'(e1.inst));
        chk({tag, ".pack1"},  64'(bus.out_pack1_o),  64'(e1.pack));
    endtask

    // One clock: edge, model update from pre-edge inputs, sample 1 unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic add_vec(input logic v1, input logic v2, input logic fl, input logic [1:0] iss,
                           input logic [31:0] a1, input logic [31:0] a2, input int ecnt,
                           input logic efull, input logic ev1, input logic ev2,
                           input logic [31:0] ea1, input logic [31:0] ea2);
        vec_t v;
        v = '{v1: v1, v2: v2, fl: fl, iss: iss, a1: a1, a2: a2, ecnt: ecnt,
              efull: efull, ev1: ev1, ev2: ev2, ea1: ea1, ea2: ea2};
        vt.push_back(v);
    endtask

    initial begin
        logic [31:0] a;

        // Directed table, starting from an empty FIFO after reset.
        for (int i = 0; i < 8; i++)
            add_vec(1, 1, 0, 0, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i),
                    2 * (i + 1), i == 7, 1, 1, 32'h100, 32'h104);
        add_vec(1, 1, 0, 0, 32'h900, 32'h904, 16, 1, 1, 1, 32'h100, 32'h104);
        add_vec(1, 0, 0, 2, 32'hA00, 32'hA04, 14, 0, 1, 1, 32'h108, 32'h10C);
        add_vec(0, 0, 0, 3, 32'h0,   32'h0,   12, 0, 1, 1, 32'h110, 32'h114);
        add_vec(0, 1, 0, 0, 32'hB00, 32'hB04, 12, 0, 1, 1, 32'h110, 32'h114);
        add_vec(1, 0, 0, 1, 32'hA00, 32'hA04, 12, 0, 1, 1, 32'h114, 32'h118);
        add_vec(1, 1, 1, 2, 32'hC00, 32'hC04, 0,  0, 0, 0, 32'h0,   32'h0);
        add_vec(1, 0, 0, 0, 32'h300, 32'h304, 1,  0, 1, 0, 32'h300, 32'h0);
        add_vec(0, 0, 0, 2, 32'h0,   32'h0,   0,  0, 0, 0, 32'h0,   32'h0);

        // Reset: asserted asynchronously mid-cycle, held 3 cycles.
        rst = 1;
        drive(0, 0, 0, 0, 0, 0);
        #2 rst = 0;
        #1;
        chk("reset.count",  64'(bus.count_o), 64'd0);
        chk("reset.valid1", 64'(bus.out_valid1_o), 64'd0);
        chk("reset.valid2", 64'(bus.out_valid2_o), 64'd0);
        chk("reset.full",   64'(bus.full_o), 64'd0);
        for (int i = 0; i < 3; i++) step("reset_hold");
        rst = 1;

        // Table vectors.
        foreach (vt[i]) begin
            drive(vt[i].v1, vt[i].v2, vt[i].a1, vt[i].a2, vt[i].iss, vt[i].fl);
            step("vec");
            chk($sformatf("vec%0d.count", i),  64'(bus.count_o),      64'(vt[i].ecnt));
            chk($sformatf("vec%0d.full", i),   64'(bus.full_o),       64'(vt[i].efull));
            chk($sformatf("vec%0d.valid1", i), 64'(bus.out_valid1_o), 64'(vt[i].ev1));
            chk($sformatf("vec%0d.valid2", i), 64'(bus.out_valid2_o), 64'(vt[i].ev2));
            chk($sformatf("vec%0d.addr1", i),  64'(bus.out_addr1_o),  64'(vt[i].ea1));
            chk($sformatf("vec%0d.addr2", i),  64'(bus.out_addr2_o),  64'(vt[i].ea2));
        end

        // Wrap: walk tail to 15 while draining, then dual push across the end.
        drive(0, 0, 0, 0, 0, 1); step("wrap_flush");
        for (int k = 0; k < 7; k++) begin
            drive(1, 1, 32'h400 + 32'(8 * k), 32'h404 + 32'(8 * k), 2, 0);
            step("wrap_fill");
        end
        drive(1, 0, 32'h480, 0, 2, 0); step("wrap_fill");
        for (int k = 0; k < 10 && bus.count_o != 0; k++) begin
            drive(0, 0, 0, 0, 2, 0);
            step("wrap_drain");
        end
        chk("wrap.drained", 64'(bus.count_o), 64'd0);
        drive(1, 1, 32'h200, 32'h204, 0, 0); step("wrap_push");
        chk("wrap.count", 64'(bus.count_o), 64'd2);
        chk("wrap.addr1", 64'(bus.out_addr1_o), 64'h200);
        chk("wrap.addr2", 64'(bus.out_addr2_o), 64'h204);
        drive(0, 0, 0, 0, 1, 0); step("wrap_pop");
        chk("wrap.pop_addr1", 64'(bus.out_addr1_o), 64'h204);
        drive(0, 0, 0, 0, 1, 0); step("wrap_pop");
        chk("wrap.empty", 64'(bus.count_o), 64'd0);

        // Simultaneous push 2 / issue 1 at count 5.
        drive(0, 0, 0, 0, 0, 1); step("sim_flush");
        drive(1, 1, 32'h500, 32'h504, 0, 0); step("sim_fill");
        drive(1, 1, 32'h508, 32'h50C, 0, 0); step("sim_fill");
        drive(1, 0, 32'h510, 0, 0, 0);       step("sim_fill");
        chk("sim.count5", 64'(bus.count_o), 64'd5);
        drive(1, 1, 32'h600, 32'h604, 1, 0); step("sim_pushpop");
        chk("sim.count6", 64'(bus.count_o), 64'd6);
        chk("sim.addr1",  64'(bus.out_addr1_o), 64'h504);
        chk("sim.addr2",  64'(bus.out_addr2_o), 64'h508);

        // Flush at count 9 with concurrent push and issue.
        drive(1, 1, 32'h700, 32'h704, 0, 0); step("fl_fill");
        drive(1, 0, 32'h708, 0, 0, 0);       step("fl_fill");
        chk("flush.count9", 64'(bus.count_o), 64'd9);
        drive(1, 1, 32'h800, 32'h804, 2, 1); step("flush");
        chk("flush.count",  64'(bus.count_o), 64'd0);
        chk("flush.valid1", 64'(bus.out_valid1_o), 64'd0);
        chk("flush.valid2", 64'(bus.out_valid2_o), 64'd0);
        chk("flush.full",   64'(bus.full_o), 64'd0);

        // Reset mid-stream clears immediately, without waiting for an edge.
        drive(1, 1, 32'hD00, 32'hD04, 0, 0); step("mrst_fill");
        drive(1, 1, 32'hD08, 32'hD0C, 0, 0); step("mrst_fill");
        #2 rst = 0;
        q.delete();
        #1;
        chk("mrst.count",  64'(bus.count_o), 64'd0);
        chk("mrst.valid1", 64'(bus.out_valid1_o), 64'd0);
        step("mrst_hold");
        rst = 1;
        drive(1, 0, 32'hE00, 0, 0, 0); step("mrst_after");
        chk("mrst.after_addr1", 64'(bus.out_addr1_o), 64'hE00);

        // Random traffic, fetch-biased so the full boundary is exercised.
        for (int i = 0; i < 600; i++) begin
            a = $urandom;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, a, $urandom,
                  2'($urandom_range(0, 3)), $urandom_range(0, 63) == 0);
            bus.in_pack0_i = {4'($urandom), 32'($urandom)};
            bus.in_pack1_i = {4'($urandom), 32'($urandom)};
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
